// File: rtl/square_root_seq.sv
// Sequential integer square root.
// Restoring, bit-serial: one root bit is decided per clock, MSB first.
// A start/done handshake wraps the datapath. Signed mode maps the result
// onto an N-bit two's-complement root range and flags overflow.
module square_root_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] sq,
    input  logic           sign,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   root,
    output logic           exact,
    output logic           ovf
);

    localparam int IW = $clog2(N);

    // Largest square whose signed root (-2^(N-1)) is representable.
    localparam logic [2*N-1:0] T_SQ    = {2'b01, {(2*N-2){1'b0}}};
    localparam logic [N-1:0]   POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]   NEG_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]   ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]  TOP_BIT = IW'(N-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   bit_reg;
    logic [2*N-1:0]  sq_reg;
    logic            sign_reg;
    logic [N-1:0]    work_reg;

    logic [N-1:0]    trial;
    logic [2*N-1:0]  trial_sq;
    logic [N-1:0]    work_next;
    logic [2*N-1:0]  final_sq;
    logic [N-1:0]    root_next;
    logic            exact_next;
    logic            ovf_next;

    // Trial step for the current bit plus the final output mapping; the
    // products are formed at full 2N width so they never truncate.
    always_comb begin
        trial      = work_reg | (ONE << bit_reg);
        trial_sq   = {{N{1'b0}}, trial} * {{N{1'b0}}, trial};
        work_next  = (trial_sq <= sq_reg) ? trial : work_reg;
        final_sq   = {{N{1'b0}}, work_next} * {{N{1'b0}}, work_next};
        root_next  = work_next;
        exact_next = (final_sq == sq_reg);
        ovf_next   = 1'b0;
        if (sign_reg) begin
            if (sq_reg == T_SQ) begin
                // Only representable signed root of T is the most negative value.
                root_next  = NEG_MIN;
                exact_next = 1'b1;
            end else if (sq_reg > T_SQ) begin
                root_next  = POS_MAX;
                exact_next = 1'b0;
                ovf_next   = 1'b1;
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bit_reg   <= TOP_BIT;
            sq_reg    <= '0;
            sign_reg  <= 1'b0;
            work_reg  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            root      <= '0;
            exact     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sq_reg    <= sq;
                        sign_reg  <= sign;
                        work_reg  <= '0;
                        bit_reg   <= TOP_BIT;
                        busy      <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    work_reg <= work_next;
                    if (bit_reg == '0) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        root      <= root_next;
                        exact     <= exact_next;
                        ovf       <= ovf_next;
                    end else begin
                        bit_reg <= bit_reg - IW'(1);
                    end
                end
                DONE: begin
                    // start is deliberately ignored here.
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_root_seq.sv
// Directed testbench for square_root_seq (N=4).
module tb_square_root_seq;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] sq;
    logic           sign;
    logic           busy;
    logic           done;
    logic [N-1:0]   root;
    logic           exact;
    logic           ovf;

    int chk_cnt = 0;
    int err_cnt = 0;

    square_root_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sq    (sq),
        .sign  (sign),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .exact (exact),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Independent reference: exhaustive floor-sqrt search plus sign mapping.
    task automatic model(input logic [2*N-1:0] s, input logic sg,
                         output logic [N-1:0] r, output logic e, output logic o);
        int f;
        f = 0;
        for (int c = 0; c < (1 << N); c++)
            if (c * c <= int'(s)) f = c;
        r = N'(f);
        e = (f * f == int'(s));
        o = 1'b0;
        if (sg) begin
            if (int'(s) == (1 << (2*N-2))) begin
                r = N'(1 << (N-1));
                e = 1'b1;
            end else if (int'(s) > (1 << (2*N-2))) begin
                r = N'((1 << (N-1)) - 1);
                e = 1'b0;
                o = 1'b1;
            end
        end
    endtask

    // One start in IDLE, then follow the run to completion, checking latency,
    // busy length and the results captured in the done cycle.
    task automatic do_op(input logic [2*N-1:0] s, input logic sg,
                         input logic [N-1:0] er, input logic ee, input logic eo);
        int lat, bcnt, dcnt;
        logic [N-1:0] r;
        logic e, o;
        r = '0; e = 1'b0; o = 1'b0;
        sq = s; sign = sg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; bcnt = 0; dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k; dcnt++;
                r = root; e = exact; o = ovf;
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
        $display("op sq=%0d sign=%0d root=%0d exact=%0d ovf=%0d lat=%0d busy=%0d",
                 s, sg, r, e, o, lat, bcnt);
        check("latency", lat, N);
        check("busy_cycles", bcnt, N + 1);
        check("done_pulses", dcnt, 1);
        check("root", r, er);
        check("exact", e, ee);
        check("ovf", o, eo);
    endtask

    initial begin
        int dcnt;
        logic [N-1:0] mr;
        logic me, mo;

        rst_n = 1'b0; start = 1'b0; sq = '0; sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_root", root, 0);
        check("rst_exact", exact, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned basics.
        do_op(8'd144, 1'b0, 4'd12, 1'b1, 1'b0);
        do_op(8'd255, 1'b0, 4'd15, 1'b0, 1'b0);
        do_op(8'd0,   1'b0, 4'd0,  1'b1, 1'b0);

        // Signed range edges.
        do_op(8'd49, 1'b1, 4'd7,     1'b1, 1'b0);
        do_op(8'd64, 1'b1, 4'b1000,  1'b1, 1'b0);
        do_op(8'd65, 1'b1, 4'd7,     1'b0, 1'b1);

        // Start during CALC and DONE is ignored; sq change after capture is too.
        sq = 8'd100; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < N + 4; k++) begin
            if (done) dcnt++;
            sq    = 8'd9;
            start = (k == 1 || k == N);
            @(posedge clk); #1;
        end
        start = 1'b0;
        $display("op sq=100 with ignored starts root=%0d exact=%0d dones=%0d", root, exact, dcnt);
        check("ign_done_pulses", dcnt, 1);
        check("ign_root", root, 10);
        check("ign_exact", exact, 1);
        check("ign_busy", busy, 0);
        do_op(8'd9, 1'b0, 4'd3, 1'b1, 1'b0);

        // Asynchronous reset two cycles into CALC.
        sq = 8'd200; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_root", root, 0);
        check("arst_exact", exact, 0);
        check("arst_ovf", ovf, 0);
        dcnt = 0;
        repeat (2) begin @(posedge clk); #1; if (done) dcnt++; end
        rst_n = 1'b1;
        repeat (N + 2) begin @(posedge clk); #1; if (done) dcnt++; end
        $display("op reset mid-calc dones=%0d root=%0d", dcnt, root);
        check("arst_no_done", dcnt, 0);
        check("arst_root_hold", root, 0);
        do_op(8'd81, 1'b0, 4'd9, 1'b1, 1'b0);

        // Full sweep, both modes, back-to-back starts.
        for (int s = 0; s < (1 << (2*N)); s++) begin
            for (int g = 0; g < 2; g++) begin
                model(8'(s), 1'(g), mr, me, mo);
                do_op(8'(s), 1'(g), mr, me, mo);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
